transform_feeder: RTL

Ordered buffer between the frame driver and the transform stage. It accepts `transform_setup_t` beats from the frame driver and queues camera updates and triangles in arrival order in a small FIFO. It presents each triangle with its model transform and the camera transform in force at that point. It also converts the frame driver's frame-complete level into a single "stream drained" pulse carrying the frame's triangle count.

---
 rtl/transform_feeder_pkg.sv | 56 +++++
 rtl/transform_feeder_if.sv | 33 +++
 rtl/transform_feeder_fifo.sv | 44 ++++
 rtl/transform_feeder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/transform_feeder_pkg.sv
// Shared types for the transform feeder: setup beats from the frame driver,
// triangle/transform payloads, and the FIFO entry format.
package transformer_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    // 3x4 row-major affine matrix, signed fixed point
    typedef logic signed [11:0][15:0] transform_t;

    typedef struct packed {
        triangle_t  triangle;
        transform_t model_transform;
        transform_t camera_transform;
        logic       model_valid;
        logic       camera_valid;
    } transform_setup_t;

    typedef enum logic {
        FEED_TRI = 1'b0,
        FEED_CAM = 1'b1
    } feed_kind_e;

    typedef struct packed {
        feed_kind_e kind;
        triangle_t  triangle;
        transform_t xform;
    } feed_entry_t;

    function automatic feed_entry_t tri_entry(input triangle_t t, input transform_t m);
        feed_entry_t e;
        e.kind     = FEED_TRI;
        e.triangle = t;
        e.xform    = m;
        return e;
    endfunction

    // Camera entries carry no triangle; the payload is zeroed
    function automatic feed_entry_t cam_entry(input transform_t c);
        feed_entry_t e;
        e.kind     = FEED_CAM;
        e.triangle = '0;
        e.xform    = c;
        return e;
    endfunction

endpackage

// File: rtl/transform_feeder_if.sv
// Bundle of the feeder's input stream, output stream and frame signals.
// master = frame driver / transform stage side, slave = the feeder.
interface transform_feeder_if #(
    parameter int CNT_W = 16
);
    import transformer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    transform_setup_t in_setup;
    logic             frame_feed_done;
    logic             out_valid;
    logic             out_ready;
    triangle_t        out_triangle;
    transform_t       out_model_transform;
    transform_t       out_camera_transform;
    logic             camera_valid;
    logic             stream_done;
    logic [CNT_W-1:0] frame_tri_count;

    modport master (
        output in_valid, in_setup, frame_feed_done, out_ready,
        input  in_ready, out_valid, out_triangle, out_model_transform,
               out_camera_transform, camera_valid, stream_done, frame_tri_count
    );

    modport slave (
        input  in_valid, in_setup, frame_feed_done, out_ready,
        output in_ready, out_valid, out_triangle, out_model_transform,
               out_camera_transform, camera_valid, stream_done, frame_tri_count
    );

endinterface

// File: rtl/transform_feeder_fifo.sv
// Register FIFO with two write ports and one read port. push1 lands in the
// slot after push0 so a camera+triangle beat stays in order.
module feed_fifo
    import transformer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push0,
    input  feed_entry_t push0_data,
    input  logic        push1,
    input  feed_entry_t push1_data,
    input  logic        pop,
    output feed_entry_t head,
    output logic [AW:0] count
);
    feed_entry_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign head = mem[rptr];

    // Storage write; data is not reset, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push0) mem[wptr] <= push0_data;
        if (push1) mem[wptr + AW'(push0)] <= push1_data;
    end

    // Pointers wrap naturally at DEPTH; count moves by pushes minus pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push0) + AW'(push1);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/transform_feeder.sv
// Ordered buffer between frame driver and transform stage: queues camera and
// triangle entries, presents each triangle with the camera in force, and
// turns the frame-complete level into one stream_done pulse with a count.
module transform_feeder
    import transformer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    transform_feeder_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    logic        cam_flag, mdl_flag, accept, push0, push1;
    feed_entry_t push0_data, push1_data, head_p0;
    logic [AW:0] fifo_count;
    logic        pop, head_is_tri, out_free, handshake, drain, ffd_rise;

    logic        out_vld_p1;
    triangle_t   out_tri_p1;
    transform_t  out_model_p1;
    transform_t  cam_p1;
    logic        cam_valid_p1;

    logic             ffd_q, done_pending, stream_done_q;
    logic [CNT_W-1:0] tri_cnt, frame_cnt_q;

    // Room for a two-entry beat is the acceptance condition
    assign bus.in_ready = (fifo_count <= READY_MAX);

    // Classify the incoming beat into zero, one or two FIFO pushes
    always_comb begin
        cam_flag   = bus.in_setup.camera_valid;
        mdl_flag   = bus.in_setup.model_valid;
        accept     = bus.in_valid && bus.in_ready;
        push0      = accept && (cam_flag || mdl_flag);
        push1      = accept && cam_flag && mdl_flag;
        push0_data = cam_flag ? cam_entry(bus.in_setup.camera_transform)
                              : tri_entry(bus.in_setup.triangle, bus.in_setup.model_transform);
        push1_data = tri_entry(bus.in_setup.triangle, bus.in_setup.model_transform);
    end

    // Pop whenever the output register can take the head; detect frame drain
    always_comb begin
        out_free    = !out_vld_p1 || bus.out_ready;
        handshake   = out_vld_p1 && bus.out_ready;
        head_is_tri = (head_p0.kind == FEED_TRI);
        pop         = (fifo_count != '0) && out_free;
        drain       = done_pending && (fifo_count == '0) && !out_vld_p1;
        ffd_rise    = bus.frame_feed_done && !ffd_q;
    end

    feed_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push0     (push0),
        .push0_data(push0_data),
        .push1     (push1),
        .push1_data(push1_data),
        .pop       (pop),
        .head      (head_p0),
        .count     (fifo_count)
    );

    // Output register: a camera pop leaves a one-cycle bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_p1   <= 1'b0;
            out_tri_p1   <= '0;
            out_model_p1 <= '0;
        end else if (out_free) begin
            out_vld_p1 <= pop && head_is_tri;
            if (pop && head_is_tri) begin
                out_tri_p1   <= head_p0.triangle;
                out_model_p1 <= head_p0.xform;
            end
        end
    end

    // Camera register only moves when the output is free, so a stalled triangle keeps its camera
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_p1       <= '0;
            cam_valid_p1 <= 1'b0;
        end else if (pop && !head_is_tri) begin
            cam_p1       <= head_p0.xform;
            cam_valid_p1 <= 1'b1;
        end
    end

    // Frame completion: edge-detect the done level, wait for drain, report and restart the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ffd_q         <= 1'b0;
            done_pending  <= 1'b0;
            stream_done_q <= 1'b0;
            frame_cnt_q   <= '0;
            tri_cnt       <= '0;
        end else begin
            ffd_q         <= bus.frame_feed_done;
            stream_done_q <= drain;
            if (drain) begin
                done_pending <= 1'b0;
                frame_cnt_q  <= tri_cnt;
                tri_cnt      <= CNT_W'(handshake);
            end else begin
                if (ffd_rise) done_pending <= 1'b1;
                if (handshake && (tri_cnt != '1)) tri_cnt <= tri_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid            = out_vld_p1;
    assign bus.out_triangle         = out_tri_p1;
    assign bus.out_model_transform  = out_model_p1;
    assign bus.out_camera_transform = cam_p1;
    assign bus.camera_valid         = cam_valid_p1;
    assign bus.stream_done          = stream_done_q;
    assign bus.frame_tri_count      = frame_cnt_q;

endmodule
